logic_pipe: RTL and testbench

Parametrised successor to the two-flop registered logic cell (f <= x1&x2, e <= x3|f).
- Generalised to WIDTH-bit vectors with a selectable bitwise op and a DEPTH-stage pipeline.
- Valid/ready handshakes on input and output, plus a transfer counter.
- Sits between a producer and a consumer that may both stall. The cross-transaction feedback (e uses the previous f) is preserved.

---
 rtl/logic_pipe_pkg.sv | 25 ++
 rtl/logic_pipe_stage.sv | 34 +++
 rtl/logic_pipe.sv | 139 +++++++++++++
 tb/tb_logic_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pipe_pkg.sv
// logic_pipe shared definitions: op encoding and the per-bit op.
package logic_pipe_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  // One bit of the selected bitwise op; callers loop it over any width.
  function automatic logic op_bit(op_e op, logic x, logic y);
    logic r;
    r = 1'b0;
    unique case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// Generic valid/ready register slice used for the plain delay stages.
// Holds its payload while valid and the downstream is not ready.
module logic_pipe_stage #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);

  logic vld_q;
  T     data_q;

  assign in_ready_o  = !vld_q || out_ready_i;
  assign out_valid_o = vld_q;
  assign out_data_o  = data_q;

  // Load a new beat (or a bubble) whenever this slot can be vacated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (in_ready_o) begin
      vld_q <= in_valid_i;
      if (in_valid_i) data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/logic_pipe.sv
// logic_pipe: f = op(a,b), e = c | f of previous transaction, DEPTH stages.
// Optional macro LOGIC_PIPE_PARITY_EN adds out_par = ^{e,f}.
module logic_pipe
  import logic_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] e,
  output logic [WIDTH-1:0] f,
  output logic [CNT_W-1:0] xfer_cnt
`ifdef LOGIC_PIPE_PARITY_EN
  ,
  output logic             out_par
`endif
);

  typedef struct packed {
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] f;
`ifdef LOGIC_PIPE_PARITY_EN
    logic             par;
`endif
  } pay_t;

  logic             vld [DEPTH];
  logic             rdy [DEPTH+1];
  pay_t             pay [1:DEPTH-1];

  logic             v0_q;
  logic [WIDTH-1:0] f0_q;
  logic [WIDTH-1:0] c0_q;
  logic [WIDTH-1:0] f0_d;
  logic             v1_q;
  pay_t             p1_q;
  pay_t             p1_d;
  logic [WIDTH-1:0] fprev_q;
  logic [CNT_W-1:0] cnt_q;

  assign vld[0]     = v0_q;
  assign vld[1]     = v1_q;
  assign pay[1]     = p1_q;
  assign rdy[0]     = !v0_q || rdy[1];
  assign rdy[1]     = !v1_q || rdy[2];
  assign rdy[DEPTH] = out_ready;

  assign in_ready  = rdy[0] && !rst;
  assign out_valid = vld[DEPTH-1];
  assign e         = pay[DEPTH-1].e;
  assign f         = pay[DEPTH-1].f;
  assign xfer_cnt  = cnt_q;
`ifdef LOGIC_PIPE_PARITY_EN
  assign out_par   = pay[DEPTH-1].par;
`endif

  // Bitwise op of the incoming operands.
  always_comb begin
    f0_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f0_d[i] = op_bit(op_e'(op), a[i], b[i]);
    end
  end

  // Stage 1 result: feedback OR with the previous transaction's f.
  always_comb begin
    p1_d   = '0;
    p1_d.e = c0_q | fprev_q;
    p1_d.f = f0_q;
`ifdef LOGIC_PIPE_PARITY_EN
    p1_d.par = ^{p1_d.e, p1_d.f};
`endif
  end

  // Stage 0 captures f0 and c on an accepted transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q <= 1'b0;
      f0_q <= '0;
      c0_q <= '0;
    end else if (rdy[0]) begin
      v0_q <= in_valid;
      if (in_valid) begin
        f0_q <= f0_d;
        c0_q <= c;
      end
    end
  end

  // Stage 1 forms e and remembers f for the next transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      p1_q    <= '0;
      fprev_q <= '0;
    end else if (rdy[1]) begin
      v1_q <= v0_q;
      if (v0_q) begin
        p1_q    <= p1_d;
        fprev_q <= f0_q;
      end
    end
  end

  for (genvar i = 2; i < DEPTH; i++) begin : g_dly
    logic_pipe_stage #(
      .T (pay_t)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (vld[i-1]),
      .in_ready_o  (rdy[i]),
      .in_data_i   (pay[i-1]),
      .out_valid_o (vld[i]),
      .out_ready_i (rdy[i+1]),
      .out_data_o  (pay[i])
    );
  end

  // Count output handshakes, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (vld[DEPTH-1] && out_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_pipe.sv
// Bench for logic_pipe: DEPTH=2/CNT_W=16 and DEPTH=3/CNT_W=4 instances
// share stimulus; each is checked against an occupancy-level model.
module tb_logic_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = '0, b = '0, c = '0;
  logic [1:0] op = '0;

  logic        rdy2, ov2, rdy3, ov3;
  logic [7:0]  e2, f2, e3, f3;
  logic [15:0] x2;
  logic [3:0]  x3;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  logic_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .a(a), .b(b), .c(c), .op(op), .out_valid(ov2),
    .out_ready(out_ready), .e(e2), .f(f2), .xfer_cnt(x2)
  );

  logic_pipe #(.WIDTH(8), .DEPTH(3), .CNT_W(4)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3),
    .a(a), .b(b), .c(c), .op(op), .out_valid(ov3),
    .out_ready(out_ready), .e(e3), .f(f3), .xfer_cnt(x3)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int dp(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic logic [7:0] opf(input logic [1:0] o,
                                     input logic [7:0] x,
                                     input logic [7:0] y);
    case (o)
      2'd0:    return x & y;
      2'd1:    return x | y;
      2'd2:    return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  // Model: per instance, a list of in-flight results with their slot index.
  logic [7:0] me [2][4];
  logic [7:0] mf [2][4];
  int         mp [2][4];
  int         n   [2];
  int         cnt [2];
  logic [7:0] fp  [2];

  always @(posedge clk or posedge rst) begin
    int  p, pp;
    bit  mv, pm, macc;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        n[k] = 0; cnt[k] = 0; fp[k] = '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        macc = in_valid && (out_ready || n[k] < dp(k));
        pp = 99; pm = 1'b1;
        for (int j = 0; j < n[k]; j++) begin
          p = mp[k][j];
          if (j == 0) mv = (p < dp(k) - 1) || out_ready;
          else        mv = (pp > p + 1) || pm;
          pp = p; pm = mv;
          if (mv) mp[k][j] = p + 1;
        end
        if (n[k] > 0 && mp[k][0] == dp(k)) begin
          for (int j = 0; j < 3; j++) begin
            me[k][j] = me[k][j+1]; mf[k][j] = mf[k][j+1];
            mp[k][j] = mp[k][j+1];
          end
          n[k]--; cnt[k]++;
        end
        if (macc) begin
          mf[k][n[k]] = opf(op, a, b);
          me[k][n[k]] = c | fp[k];
          mp[k][n[k]] = 0;
          fp[k] = mf[k][n[k]];
          n[k]++;
        end
      end
    end
  end

  logic        dov [2];
  logic        drd [2];
  logic [7:0]  de  [2];
  logic [7:0]  df  [2];
  logic [15:0] dx  [2];
  assign dov[0] = ov2;  assign dov[1] = ov3;
  assign drd[0] = rdy2; assign drd[1] = rdy3;
  assign de[0]  = e2;   assign de[1]  = e3;
  assign df[0]  = f2;   assign df[1]  = f3;
  assign dx[0]  = x2;   assign dx[1]  = {12'h0, x3};

  // Compare every cycle, mid-period.
  always @(negedge clk) begin
    bit eov;
    for (int k = 0; k < 2; k++) begin
      eov = n[k] > 0 && mp[k][0] == dp(k) - 1;
      chk($sformatf("d%0d out_valid", k), dov[k], eov);
      chk($sformatf("d%0d in_ready", k), drd[k],
          !rst && (out_ready || n[k] < dp(k)));
      chk($sformatf("d%0d xfer_cnt", k), dx[k],
          (k == 0) ? (cnt[k] & 32'hffff) : (cnt[k] & 32'hf));
      if (eov) begin
        chk($sformatf("d%0d e", k), de[k], me[k][0]);
        chk($sformatf("d%0d f", k), df[k], mf[k][0]);
      end
    end
  end

  // Log of DEPTH=2 output handshakes for literal checks.
  logic [7:0] le[$], lf[$];
  always @(posedge clk) begin
    if (!rst && ov2 && out_ready) begin
      le.push_back(e2);
      lf.push_back(f2);
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] ta, input logic [7:0] tb,
                      input logic [7:0] tc, input logic [1:0] to);
    int g;
    bit r;
    a = ta; b = tb; c = tc; op = to; in_valid = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      r = rdy2;
      @(posedge clk);
      #2;
      g++;
    end while (!r && g < 50);
    chk("send accepted", r, 1'b1);
    in_valid = 1'b0;
  endtask

  logic [7:0] bpa [4];
  logic [1:0] bpo [4];

  initial begin
    int base, i;
    bit r;
    bpa = '{8'h11, 8'h11, 8'h11, 8'h11};
    bpo = '{2'd0, 2'd1, 2'd2, 2'd3};

    // Reset and release.
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after release", rdy2, 1'b1);
    chk("out_valid after reset", ov2, 1'b0);
    tick(1);

    // Feedback and latency.
    send(8'hF0, 8'h3C, 8'h01, 2'd0);
    @(negedge clk);
    chk("T1 not yet visible", ov2, 1'b0);
    tick(1);
    @(negedge clk);
    chk("T1 visible", ov2, 1'b1);
    chk("T1 f", f2, 8'h30);
    chk("T1 e", e2, 8'h01);
    tick(1);
    base = lf.size();
    send(8'hFF, 8'h0F, 8'h80, 2'd0);
    tick(3);
    chk("T2 f", lf[base], 8'h0F);
    chk("T2 e", le[base], 8'hB0);

    // All four ops back-to-back.
    base = lf.size();
    for (int k = 0; k < 4; k++) send(8'hAA, 8'hCC, 8'h00, 2'(k));
    tick(3);
    chk("AND f", lf[base], 8'h88);
    chk("OR f", lf[base+1], 8'hEE);
    chk("XOR f", lf[base+2], 8'h66);
    chk("NAND f", lf[base+3], 8'h77);
    chk("AND e", le[base], 8'h0F);
    chk("OR e", le[base+1], 8'h88);
    chk("XOR e", le[base+2], 8'hEE);
    chk("NAND e", le[base+3], 8'h66);

    // Backpressure for six cycles.
    out_ready = 1'b0;
    base = lf.size();
    i = 0;
    a = bpa[0]; b = 8'h33; c = 8'h00; op = bpo[0]; in_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      r = rdy2;
      @(posedge clk);
      #2;
      if (r && i < 3) begin
        i++;
        a = bpa[i]; op = bpo[i];
      end
    end
    chk("bp accepted", i, 2);
    @(negedge clk);
    chk("bp in_ready", rdy2, 1'b0);
    chk("bp out_valid", ov2, 1'b1);
    chk("bp hold f", f2, 8'h11);
    chk("bp hold e", e2, 8'h77);
    in_valid = 1'b0;
    tick(2);
    @(negedge clk);
    chk("bp still f", f2, 8'h11);
    chk("bp still e", e2, 8'h77);
    tick(1);
    out_ready = 1'b1;
    tick(4);
    chk("bp delivered", lf.size() - base, 2);
    chk("bp f0", lf[base], 8'h11);
    chk("bp e0", le[base], 8'h77);
    chk("bp f1", lf[base+1], 8'h33);
    chk("bp e1", le[base+1], 8'h11);
    chk("bp xfer_cnt", x2, 16'd8);

    // Intermittent consumer stalls.
    fork
      begin
        for (int j = 0; j < 12; j++)
          send(8'(j * 17), 8'h5A, 8'(j), 2'(j % 4));
      end
      begin
        for (int j = 0; j < 30; j++) begin
          tick(1);
          out_ready = (j % 3) != 0;
        end
      end
    join
    out_ready = 1'b1;
    tick(5);

    // Reset with two transactions pending.
    out_ready = 1'b0;
    send(8'h01, 8'h01, 8'h00, 2'd0);
    send(8'h02, 8'h02, 8'h00, 2'd0);
    rst = 1'b1;
    #1;
    chk("rst out_valid", ov2, 1'b0);
    chk("rst e", e2, 8'h00);
    chk("rst f", f2, 8'h00);
    chk("rst xfer_cnt", x2, 16'd0);
    chk("rst in_ready", rdy2, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready after mid reset", rdy2, 1'b1);
    tick(1);
    out_ready = 1'b1;
    base = lf.size();
    send(8'h00, 8'h00, 8'h05, 2'd0);
    tick(3);
    chk("post-reset count", lf.size() - base, 1);
    chk("post-reset e", le[base], 8'h05);
    chk("post-reset f", lf[base], 8'h00);

    // Counter wrap on the CNT_W=4 instance.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    for (int j = 0; j < 17; j++) send(8'(j), 8'hFF, 8'h00, 2'd1);
    tick(5);
    chk("cnt16 after 17", x2, 16'd17);
    chk("cnt4 wrap", x3, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
